// File: rtl/im_issue_seq.sv
// im_issue_seq: buffers host instruction words in a small FIFO and issues
// them to the CPU instruction memory as single-cycle we_IM pulses separated
// by a fixed idle gap. Jump opcodes consume a trailing immediate word.
module im_issue_seq #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP    = 2,
  parameter logic [3:0]  JMP_OP = 4'h7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic                     in_ready,
  output logic                     we_IM,
  output logic [15:0]              codein,
  output logic [11:0]              immd,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [AW:0]   LP_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_IMM,
    S_GAPW
  } state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  state_t        r_state;
  logic [GW-1:0] r_gap;
  logic          r_we;
  logic [15:0]   r_code;
  logic [11:0]   r_immd;

  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_head;

  assign w_head   = r_mem[r_rptr];
  assign in_ready = ~rst & (r_cnt < LP_DEPTH);
  assign w_push   = in_valid & in_ready;
  // The head is consumed on the edge that enters ISSUE, or on the edge that
  // captures the immediate in WAIT_IMM; both require a non-empty FIFO.
  assign w_pop    = (r_cnt != '0) &
                    (((r_state == S_IDLE) & en) | (r_state == S_WAIT_IMM));

  assign we_IM    = r_we;
  assign codein   = r_code;
  assign immd     = r_immd;
  assign fifo_cnt = r_cnt;
  assign busy     = (r_state != S_IDLE) | (r_cnt != '0);

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Issue sequencer with registered we_IM / codein / immd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_we    <= 1'b0;
      r_code  <= '0;
      r_immd  <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_ISSUE;
            r_we    <= 1'b1;
            r_code  <= w_head;
          end
        end
        S_ISSUE: begin
          if (r_code[15:12] == JMP_OP) begin
            r_state <= S_WAIT_IMM;
          end else begin
            r_state <= S_GAPW;
            r_gap   <= GAP_LOAD;
          end
        end
        S_WAIT_IMM: begin
          if (w_pop) begin
            r_immd  <= w_head[11:0];
            r_state <= S_GAPW;
            r_gap   <= GAP_LOAD;
          end
        end
        S_GAPW: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/im_issue_seq.md
IM_ISSUE_SEQ -- requirements
Module: im_issue_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning instruction FIFO depth in 16-bit words (power of two, at least 2).
REQ-002 The block SHALL have parameter GAP, default 2, meaning the number of idle cycles inserted after each issued instruction (at least 1).
REQ-003 The block SHALL have parameter JMP_OP, default 4'h7, meaning the opcode (codein[15:12]) that carries a trailing 12-bit immediate word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: issue enable.
REQ-007 The block SHALL have port in_valid, input, 1 bit: host word valid.
REQ-008 The block SHALL have port in_data, input, 16 bits: host instruction or immediate word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: FIFO can accept a word.
REQ-010 The block SHALL have port we_IM, output, 1 bit: instruction-memory write strobe to the CPU.
REQ-011 The block SHALL have port codein, output, 16 bits: instruction word to the CPU.
REQ-012 The block SHALL have port immd, output, 12 bits: jump immediate to the CPU.
REQ-013 The block SHALL have port fifo_cnt, output, log2(DEPTH)+1 bits: FIFO occupancy.
REQ-014 The block SHALL have port busy, output, 1 bit: state not IDLE or fifo_cnt nonzero.

Function
REQ-015 A word SHALL be accepted at a rising edge when in_valid and in_ready are both 1; in_ready SHALL equal (fifo_cnt < DEPTH).
REQ-016 A push while full SHALL be ignored (in_ready low); a simultaneous push and pop SHALL leave fifo_cnt unchanged; pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_IMM and GAPW.
REQ-018 IDLE SHALL go to ISSUE when en=1 and fifo_cnt>0, and otherwise stay in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle, with we_IM=1, codein=FIFO head, and the head popped.
REQ-020 From ISSUE, the FSM SHALL go to WAIT_IMM if codein[15:12]==JMP_OP, and otherwise to GAPW.
REQ-021 WAIT_IMM SHALL hold with we_IM=0 until fifo_cnt>0, then pop one word, load immd <= word[11:0] (visible the next cycle), and go to GAPW; en SHALL NOT affect WAIT_IMM.
REQ-022 GAPW SHALL last exactly GAP cycles, then go to IDLE; we_IM SHALL be 0 throughout.
REQ-023 The resulting we_IM pulse period SHALL be GAP+2 cycles for non-jump words.
REQ-024 The first we_IM pulse SHALL occur in the cycle starting two edges after acceptance into an empty FIFO from IDLE.
REQ-025 codein SHALL hold its last issued value between pulses.
REQ-026 immd SHALL hold until the next jump immediate is loaded.
REQ-027 we_IM SHALL be registered and glitch-free, and never high for two consecutive cycles.
REQ-028 en falling during ISSUE, WAIT_IMM or GAPW SHALL NOT abort the sequence; it only blocks the next IDLE->ISSUE transition.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL go to IDLE, empty the FIFO, and clear the GAP counter.
REQ-030 While rst=1, outputs SHALL be: we_IM=0, codein=16'h0000, immd=12'h000, fifo_cnt=0, busy=0, in_ready=0.
REQ-031 in_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard queued words and any pending immediate, and SHALL produce no further we_IM pulse.

Verification
REQ-033 Scenario: rst=1 for 2 cycles, then release -> all outputs 0, then in_ready=1 with fifo_cnt=0.
REQ-034 Scenario: en=1, push 16'h6001, 16'h4000, 16'h5001 back-to-back -> three single-cycle we_IM pulses, codein 6001/4000/5001 in order, period 4 cycles, first pulse 2 cycles after first acceptance.
REQ-035 Scenario: push 16'h7111 then 16'h0FEB -> exactly one we_IM pulse with codein=7111, and immd=12'hFEB two cycles after that pulse.
REQ-036 Scenario: push 16'h7111, wait 6 cycles, then push 16'h0FEB -> FSM held in WAIT_IMM with busy=1 and no we_IM during the wait; immd=FEB after the push.
REQ-037 Scenario: en=0, push 5 words -> in_ready=0 after the 4th, 5th dropped, fifo_cnt=4; then en=1 -> exactly 4 pulses in push order.
REQ-038 Scenario: 3 words queued, assert rst during the first GAPW -> no further we_IM, fifo_cnt=0, codein=0.
